vopp_measure: RTL



---
 rtl/vopp_measure_if.sv | 38 +++
 rtl/vopp_measure.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/vopp_measure_if.sv
// ----------------------------------------------------------------------------
// vopp_measure_if
// Sample-path and display-side signal bundle for the peak-to-peak measurement
// stage.
//   master : sample source / display consumer (drives data_in, data_valid, hold)
//   slave  : vopp_measure (drives the digits, max/min codes and update pulse)
// Signals:
//   data_in    [7:0]  unsigned ADC code
//   data_valid        data_in holds a valid sample this cycle
//   hold              freeze the displayed outputs
//   vopp_num_h [3:0]  BCD volts digit
//   vopp_num_d [3:0]  BCD 0.1 V digit
//   vopp_num_u [3:0]  BCD 0.01 V digit
//   vopp_max   [7:0]  max code of the last completed window
//   vopp_min   [7:0]  min code of the last completed window
//   vopp_valid        one-cycle pulse when the outputs update
// ----------------------------------------------------------------------------
interface vopp_measure_if;
    logic [7:0] data_in;
    logic       data_valid;
    logic       hold;
    logic [3:0] vopp_num_h;
    logic [3:0] vopp_num_d;
    logic [3:0] vopp_num_u;
    logic [7:0] vopp_max;
    logic [7:0] vopp_min;
    logic       vopp_valid;

    modport master (
        output data_in, data_valid, hold,
        input  vopp_num_h, vopp_num_d, vopp_num_u, vopp_max, vopp_min, vopp_valid
    );

    modport slave (
        input  data_in, data_valid, hold,
        output vopp_num_h, vopp_num_d, vopp_num_u, vopp_max, vopp_min, vopp_valid
    );
endinterface

// File: rtl/vopp_measure.sv
// ----------------------------------------------------------------------------
// vopp_measure
// Peak-to-peak voltage measurement. Tracks the min/max ADC code over a fixed
// window of WIN_LEN clk_AD cycles, scales the span to 10 mV units
// (span * FULL_SCALE / 255, rounded) with a bit-serial restoring divider, then
// converts the quotient to three BCD digits with a bit-serial double-dabble.
// Outputs refresh exactly 29 edges after each window's latch edge unless hold
// is high on the update edge, in which case that result is dropped.
// Ports:
//   clk_AD : ADC sample clock, the only clock
//   rst    : synchronous, active-high reset
//   bus    : vopp_measure_if.slave (samples in, digits/max/min/valid out)
// ----------------------------------------------------------------------------
// state  | meaning
// S_IDLE | waiting for the latch edge at the end of a window
// S_DIV  | 18 edges: restoring divide of span*FULL_SCALE+127 by 255
// S_BCD  | 10 edges: shift-add-3 conversion of the 10-bit quotient
// S_UPD  | 1 edge: load outputs and pulse vopp_valid unless hold is set
// ----------------------------------------------------------------------------
module vopp_measure #(
    parameter int unsigned WIN_LEN    = 100000,
    parameter int unsigned FULL_SCALE = 500
) (
    input  logic          clk_AD,
    input  logic          rst,
    vopp_measure_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_BCD,
        S_UPD
    } state_t;

    state_t      state;
    logic [23:0] win_cnt;
    logic [7:0]  run_max;
    logic [7:0]  run_min;
    logic        any_smp;

    logic [7:0]  cap_max;
    logic [7:0]  cap_min;
    logic [4:0]  step_cnt;
    logic [17:0] dvd;
    logic [7:0]  rem;
    logic [8:0]  quot;
    logic [9:0]  bin;
    logic [11:0] bcd;

    logic [3:0]  num_h_q;
    logic [3:0]  num_d_q;
    logic [3:0]  num_u_q;
    logic [7:0]  max_q;
    logic [7:0]  min_q;
    logic        valid_q;

    logic        last_cyc;
    logic [7:0]  acc_max;
    logic [7:0]  acc_min;
    logic        acc_any;
    logic [7:0]  acc_diff;
    logic [17:0] dvd_init;
    logic [8:0]  rem_sh;
    logic        q_bit;
    logic [7:0]  rem_nx;
    logic [11:0] bcd_adj;
    logic [11:0] bcd_nx;

    assign last_cyc = (win_cnt == 24'(WIN_LEN - 1));

    // Running extremes including the current cycle's sample, so a sample on
    // the last cycle of a window is part of what gets captured at the latch.
    always_comb begin
        acc_max = run_max;
        acc_min = run_min;
        acc_any = any_smp;
        if (bus.data_valid) begin
            if (bus.data_in > run_max) acc_max = bus.data_in;
            if (bus.data_in < run_min) acc_min = bus.data_in;
            acc_any = 1'b1;
        end
    end

    assign acc_diff = acc_any ? (acc_max - acc_min) : 8'd0;

    // +127 gives round-to-nearest of span*FULL_SCALE/255; max value
    // 255*999+127 still fits 18 bits.
    assign dvd_init = 18'(acc_diff) * 18'(FULL_SCALE) + 18'd127;

    // Partial remainder is always < 255, so the shifted value fits 9 bits.
    assign rem_sh = {rem, dvd[17]};
    assign q_bit  = (rem_sh >= 9'd255);
    assign rem_nx = q_bit ? 8'(rem_sh - 9'd255) : rem_sh[7:0];

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 3; i++) begin
            if (bcd_adj[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_adj[4*i +: 4] + 4'd3;
        end
        // q <= 999 keeps the top bit clear, so dropping it loses nothing.
        bcd_nx = 12'({bcd_adj, bin[9]});
    end

    always_ff @(posedge clk_AD) begin
        if (rst) begin
            state    <= S_IDLE;
            win_cnt  <= 24'd0;
            run_max  <= 8'h00;
            run_min  <= 8'hFF;
            any_smp  <= 1'b0;
            cap_max  <= 8'h00;
            cap_min  <= 8'h00;
            step_cnt <= 5'd0;
            dvd      <= 18'd0;
            rem      <= 8'd0;
            quot     <= 9'd0;
            bin      <= 10'd0;
            bcd      <= 12'd0;
            num_h_q  <= 4'd0;
            num_d_q  <= 4'd0;
            num_u_q  <= 4'd0;
            max_q    <= 8'h00;
            min_q    <= 8'h00;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;

            if (last_cyc) begin
                win_cnt <= 24'd0;
                run_max <= 8'h00;
                run_min <= 8'hFF;
                any_smp <= 1'b0;
            end else begin
                win_cnt <= win_cnt + 24'd1;
                run_max <= acc_max;
                run_min <= acc_min;
                any_smp <= acc_any;
            end

            case (state)
                S_IDLE: begin
                    if (last_cyc) begin
                        cap_max  <= acc_any ? acc_max : 8'h00;
                        cap_min  <= acc_any ? acc_min : 8'h00;
                        dvd      <= dvd_init;
                        rem      <= 8'd0;
                        quot     <= 9'd0;
                        step_cnt <= 5'd17;
                        state    <= S_DIV;
                    end
                end
                S_DIV: begin
                    dvd  <= {dvd[16:0], 1'b0};
                    rem  <= rem_nx;
                    quot <= {quot[7:0], q_bit};
                    if (step_cnt == 5'd0) begin
                        bin      <= {quot, q_bit};
                        bcd      <= 12'd0;
                        step_cnt <= 5'd9;
                        state    <= S_BCD;
                    end else begin
                        step_cnt <= step_cnt - 5'd1;
                    end
                end
                S_BCD: begin
                    bcd <= bcd_nx;
                    bin <= {bin[8:0], 1'b0};
                    if (step_cnt == 5'd0) begin
                        state <= S_UPD;
                    end else begin
                        step_cnt <= step_cnt - 5'd1;
                    end
                end
                S_UPD: begin
                    if (!bus.hold) begin
                        num_h_q <= bcd[11:8];
                        num_d_q <= bcd[7:4];
                        num_u_q <= bcd[3:0];
                        max_q   <= cap_max;
                        min_q   <= cap_min;
                        valid_q <= 1'b1;
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.vopp_num_h = num_h_q;
    assign bus.vopp_num_d = num_d_q;
    assign bus.vopp_num_u = num_u_q;
    assign bus.vopp_max   = max_q;
    assign bus.vopp_min   = min_q;
    assign bus.vopp_valid = valid_q;

endmodule
